// File: rtl/rvx_fwd_hazard_unit_pkg.sv
// rvx_fwd_hazard_unit_pkg: opcodes, MDU decode constants and scoreboard types
package rvx_fwd_hazard_unit_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_L      = 7'b0000011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam int         F3_DIV_BIT = 2;
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;
  typedef enum logic {MDU_IDLE, MDU_BUSY} mdu_state_e;
endpackage

// File: rtl/rvx_hazard_scoreboard.sv
// rvx_hazard_scoreboard: in-flight destination shift register with parallel rs1/rs2 match
module rvx_hazard_scoreboard
  import rvx_fwd_hazard_unit_pkg::*;
#(
  parameter int FWD_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 bubble,
  input  sb_entry_t            ins,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic [FWD_DEPTH-1:0] match_a,
  output logic [FWD_DEPTH-1:0] match_b,
  output logic [FWD_DEPTH-1:0] is_load
);
  sb_entry_t [FWD_DEPTH-1:0] ent;
  always_ff @(posedge clk or negedge rst)
    if (!rst) ent <= '0;
    else if (!hold) begin
      ent[0] <= bubble ? '0 : ins;
      for (int p = 1; p < FWD_DEPTH; p++) ent[p] <= ent[p-1];
    end
  for (genvar p = 0; p < FWD_DEPTH; p++) begin : g_m
    assign match_a[p] = ent[p].valid && ent[p].rd != 5'd0 && ent[p].rd == rs1;
    assign match_b[p] = ent[p].valid && ent[p].rd != 5'd0 && ent[p].rd == rs2;
    assign is_load[p] = ent[p].is_load;
  end
endmodule

// File: rtl/rvx_fwd_hazard_unit.sv
// rvx_fwd_hazard_unit: operand forwarding, load-use stall and DIV/REM freeze for the RVX pipeline
module rvx_fwd_hazard_unit
  import rvx_fwd_hazard_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int MDU_LAT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               id_inst_i,
  input  logic                      id_valid_i,
  input  logic                      flush_i,
  input  logic [XLEN-1:0]           rs1_data_i,
  input  logic [XLEN-1:0]           rs2_data_i,
  input  logic [FWD_DEPTH*XLEN-1:0] fwd_data_i,
  output logic [XLEN-1:0]           ex_src_a_o,
  output logic [XLEN-1:0]           ex_src_b_o,
  output logic [2:0]                fwd_sel_a_o,
  output logic [2:0]                fwd_sel_b_o,
  output logic                      stall_if_o,
  output logic                      bubble_ex_o,
  output logic                      freeze_o
);
  localparam int CW = $clog2(MDU_LAT);
  localparam logic [2:0] LL = 3'(LOAD_LAT);
  logic [6:0] op;
  logic [4:0] rs1, rs2;
  sb_entry_t ins;
  logic id_div, div_ex, freeze, lu, ld_a, ld_b;
  logic [FWD_DEPTH-1:0] match_a, match_b, is_load;
  logic [2:0] s_a, s_b, sel_a, sel_b;
  mdu_state_e state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  assign op  = id_inst_i[6:0];
  assign rs1 = (id_valid_i && !(op inside {OP_LUI, OP_AUIPC, OP_JAL})) ? id_inst_i[19:15] : 5'd0;
  assign rs2 = (id_valid_i && (op inside {OP_R, OP_S, OP_B})) ? id_inst_i[24:20] : 5'd0;
  assign ins = '{valid: id_valid_i,
                 rd: (id_valid_i && !(op inside {OP_S, OP_B})) ? id_inst_i[11:7] : 5'd0,
                 is_load: id_valid_i && op == OP_L};
  assign id_div = id_valid_i && op == OP_R && id_inst_i[31:25] == F7_MULDIV &&
                  |(id_inst_i[14:12] & (3'b001 << F3_DIV_BIT));
  rvx_hazard_scoreboard #(.FWD_DEPTH(FWD_DEPTH)) u_sb (
    .clk(clk), .rst(rst), .hold(freeze), .bubble(bubble_ex_o), .ins(ins),
    .rs1(rs1), .rs2(rs2), .match_a(match_a), .match_b(match_b), .is_load(is_load)
  );
  // Walk oldest to youngest so the youngest producer wins
  always_comb begin
    s_a  = 3'd0;
    s_b  = 3'd0;
    ld_a = 1'b0;
    ld_b = 1'b0;
    for (int p = FWD_DEPTH - 1; p >= 0; p--) begin
      if (match_a[p]) begin
        s_a  = 3'(p + 1);
        ld_a = is_load[p];
      end
      if (match_b[p]) begin
        s_b  = 3'(p + 1);
        ld_b = is_load[p];
      end
    end
  end
  assign lu          = (ld_a && s_a <= LL) || (ld_b && s_b <= LL);
  assign freeze      = state == MDU_BUSY;
  assign freeze_o    = freeze;
  assign stall_if_o  = !freeze && !flush_i && lu;
  assign bubble_ex_o = !freeze && (flush_i || lu);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sel_a  <= 3'd0;
      sel_b  <= 3'd0;
      div_ex <= 1'b0;
    end else if (!freeze) begin
      sel_a  <= bubble_ex_o ? 3'd0 : s_a;
      sel_b  <= bubble_ex_o ? 3'd0 : s_b;
      div_ex <= !bubble_ex_o && id_div;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  // A divide entering EX arms the counter; BUSY lasts MDU_LAT-1 cycles
  always_comb begin
    state_d = freeze ? (cnt == CW'(1) ? MDU_IDLE : MDU_BUSY) : (div_ex ? MDU_BUSY : MDU_IDLE);
    cnt_d   = freeze ? cnt - CW'(1) : CW'(MDU_LAT - 1);
  end
  always_comb begin
    ex_src_a_o = rs1_data_i;
    ex_src_b_o = rs2_data_i;
    for (int s = 1; s <= FWD_DEPTH; s++) begin
      if (sel_a == 3'(s)) ex_src_a_o = fwd_data_i[(s-1)*XLEN +: XLEN];
      if (sel_b == 3'(s)) ex_src_b_o = fwd_data_i[(s-1)*XLEN +: XLEN];
    end
  end
  assign fwd_sel_a_o = sel_a;
  assign fwd_sel_b_o = sel_b;
endmodule
